// File: rtl/bp_update_unit.sv
// bp_update_unit: branch-resolution update unit.
// Keeps a table of 2-bit saturating direction counters indexed by res_pc_i[IDX_SIZE+1:2].
// Taken branches whose counter becomes weakly/strongly taken are queued as BTB write
// requests and presented on a valid/ready port.
// Optional feature macro: BP_UPDATE_COALESCE_EN merges a push into the newest queued entry
// when both carry the same index.
module bp_update_unit #(
    parameter int unsigned IDX_SIZE = 4,
    parameter int unsigned FIFO_LOG = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                res_valid_i,
    input  logic [31:0]         res_pc_i,
    input  logic [31:0]         res_target_i,
    input  logic                res_taken_i,
    input  logic [IDX_SIZE-1:0] pred_idx_i,
    output logic [1:0]          pred_state_o,
    output logic                upd_valid_o,
    input  logic                upd_ready_i,
    output logic [IDX_SIZE-1:0] upd_idx_o,
    output logic [31:0]         upd_pc_o,
    output logic [31:0]         upd_target_o,
    output logic                upd_dropped_o
);

    localparam int unsigned NUM_CTR = 1 << IDX_SIZE;
    localparam int unsigned DEPTH   = 1 << FIFO_LOG;
    localparam int unsigned CNT_W   = FIFO_LOG + 1;

    typedef struct packed {
        logic [IDX_SIZE-1:0] idx;
        logic [31:0]         pc;
        logic [31:0]         target;
    } upd_entry_t;

    logic [1:0]          ctr_q [NUM_CTR];
    upd_entry_t          fifo_q [DEPTH];
    logic [FIFO_LOG-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_LOG-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                dropped_q, dropped_d;

    logic [IDX_SIZE-1:0] res_idx;
    logic [1:0]          cur_ctr;
    logic [1:0]          new_ctr_d;
    logic [FIFO_LOG-1:0] last_ptr;
    logic                fifo_empty;
    logic                fifo_full;
    logic                qualify;
    logic                pop;
    logic                push;
    logic                coalesce;

    // Counter update and queue control, all derived from state before this edge.
    always_comb begin
        res_idx    = res_pc_i[IDX_SIZE+1:2];
        cur_ctr    = ctr_q[res_idx];
        new_ctr_d  = cur_ctr;
        last_ptr   = wr_ptr_q - FIFO_LOG'(1);
        fifo_empty = (count_q == CNT_W'(0));
        fifo_full  = (count_q == CNT_W'(DEPTH));
        coalesce   = 1'b0;
        push       = 1'b0;
        dropped_d  = 1'b0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (res_taken_i) begin
            if (cur_ctr != 2'b11) new_ctr_d = cur_ctr + 2'd1;
        end else begin
            if (cur_ctr != 2'b00) new_ctr_d = cur_ctr - 2'd1;
        end

        qualify = res_valid_i && res_taken_i && new_ctr_d[1];
        pop     = !fifo_empty && upd_ready_i;

`ifdef BP_UPDATE_COALESCE_EN
        // Newest entry is popping only when it is also the sole entry.
        coalesce = qualify && !fifo_empty && (fifo_q[last_ptr].idx == res_idx)
                   && !(pop && (count_q == CNT_W'(1)));
`endif

        if (qualify && !coalesce) begin
            if (!fifo_full || pop) push = 1'b1;
            else                   dropped_d = 1'b1;
        end

        if (push) wr_ptr_d = wr_ptr_q + FIFO_LOG'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + FIFO_LOG'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Direction counter table; reset to weakly not-taken.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NUM_CTR); i++) ctr_q[i] <= 2'b01;
        end else if (res_valid_i) begin
            ctr_q[res_idx] <= new_ctr_d;
        end
    end

    // Queue storage: new slot on push, in-place overwrite on coalesce.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) fifo_q[i] <= '0;
        end else if (push) begin
            fifo_q[wr_ptr_q] <= '{idx: res_idx, pc: res_pc_i, target: res_target_i};
        end else if (coalesce) begin
            fifo_q[last_ptr].pc     <= res_pc_i;
            fifo_q[last_ptr].target <= res_target_i;
        end
    end

    // Queue pointers, occupancy and drop pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            dropped_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            dropped_q <= dropped_d;
        end
    end

    // Head presentation; fields read zero when nothing is queued.
    always_comb begin
        upd_valid_o  = !fifo_empty;
        upd_idx_o    = '0;
        upd_pc_o     = '0;
        upd_target_o = '0;
        if (!fifo_empty) begin
            upd_idx_o    = fifo_q[rd_ptr_q].idx;
            upd_pc_o     = fifo_q[rd_ptr_q].pc;
            upd_target_o = fifo_q[rd_ptr_q].target;
        end
    end

    assign pred_state_o  = ctr_q[pred_idx_i];
    assign upd_dropped_o = dropped_q;

endmodule

// File: tb/tb_bp_update_unit.sv
// Directed self-checking bench for bp_update_unit (default and coalescing builds).
module tb_bp_update_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        res_valid;
    logic [31:0] res_pc;
    logic [31:0] res_target;
    logic        res_taken;
    logic [3:0]  pred_idx;
    logic [1:0]  pred_state;
    logic        upd_valid;
    logic        upd_ready;
    logic [3:0]  upd_idx;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_dropped;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bp_update_unit #(.IDX_SIZE(4), .FIFO_LOG(2)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .res_valid_i  (res_valid),
        .res_pc_i     (res_pc),
        .res_target_i (res_target),
        .res_taken_i  (res_taken),
        .pred_idx_i   (pred_idx),
        .pred_state_o (pred_state),
        .upd_valid_o  (upd_valid),
        .upd_ready_i  (upd_ready),
        .upd_idx_o    (upd_idx),
        .upd_pc_o     (upd_pc),
        .upd_target_o (upd_target),
        .upd_dropped_o(upd_dropped)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic report(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
        res_valid  = 1'b1;
        res_pc     = pc;
        res_target = tgt;
        res_taken  = taken;
    endtask

    task automatic idle();
        res_valid  = 1'b0;
        res_pc     = '0;
        res_target = '0;
        res_taken  = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] tgt);
        check({tag, "_valid"}, 32'(upd_valid), 32'd1);
        check({tag, "_idx"}, 32'(upd_idx), 32'(pc[5:2]));
        check({tag, "_pc"}, upd_pc, pc);
        check({tag, "_tgt"}, upd_target, tgt);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        upd_ready = 1'b0;
        pred_idx  = 4'd0;
        #12;
        // Reset state
        check("rst_valid", 32'(upd_valid), 32'd0);
        check("rst_dropped", 32'(upd_dropped), 32'd0);
        check("rst_idx", 32'(upd_idx), 32'd0);
        check("rst_pc", upd_pc, 32'd0);
        check("rst_tgt", upd_target, 32'd0);
        check("rst_pred0", 32'(pred_state), 32'd1);
        tick();
        rst = 1'b0;

        // Two taken reports at idx 0: 01 -> 10 -> 11
        report(32'h40, 32'h80, 1'b1);
        tick();
        check("t1_pred_a", 32'(pred_state), 32'd2);
        check_head("t1_head_a", 32'h40, 32'h80);
        tick();
        idle();
        check("t1_pred_b", 32'(pred_state), 32'd3);
        check_head("t1_head_b", 32'h40, 32'h80);
        upd_ready = 1'b1;
        tick();
`ifdef BP_UPDATE_COALESCE_EN
        check("t1_after_pop1", 32'(upd_valid), 32'd0);
`else
        check_head("t1_after_pop1", 32'h40, 32'h80);
`endif
        tick();
        check("t1_after_pop2", 32'(upd_valid), 32'd0);
        upd_ready = 1'b0;

        // Back-to-back same-index reports with a new target
        report(32'h40, 32'h80, 1'b1);
        tick();
        report(32'h40, 32'h90, 1'b1);
        tick();
        idle();
`ifdef BP_UPDATE_COALESCE_EN
        check_head("co_head", 32'h40, 32'h90);
`else
        check_head("co_head", 32'h40, 32'h80);
`endif
        upd_ready = 1'b1;
        tick();
`ifdef BP_UPDATE_COALESCE_EN
        check("co_after_pop1", 32'(upd_valid), 32'd0);
`else
        check_head("co_after_pop1", 32'h40, 32'h90);
`endif
        tick();
        check("co_after_pop2", 32'(upd_valid), 32'd0);
        upd_ready = 1'b0;

        // Not-taken at idx 1: 01 -> 00 -> 00, nothing queued
        pred_idx = 4'd1;
        report(32'h44, 32'h100, 1'b0);
        tick();
        check("nt_pred_a", 32'(pred_state), 32'd0);
        check("nt_valid_a", 32'(upd_valid), 32'd0);
        tick();
        idle();
        check("nt_pred_b", 32'(pred_state), 32'd0);
        check("nt_valid_b", 32'(upd_valid), 32'd0);

        // Asynchronous reset with three entries queued
        report(32'h48, 32'h148, 1'b1);
        tick();
        report(32'h4C, 32'h14C, 1'b1);
        tick();
        report(32'h50, 32'h150, 1'b1);
        tick();
        idle();
        check_head("ar_head", 32'h48, 32'h148);
        pred_idx = 4'd2;
        #1;
        check("ar_pred2_pre", 32'(pred_state), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("ar_valid", 32'(upd_valid), 32'd0);
        check("ar_pc", upd_pc, 32'd0);
        check("ar_pred2", 32'(pred_state), 32'd1);
        pred_idx = 4'd1;
        #1;
        check("ar_pred1", 32'(pred_state), 32'd1);
        pred_idx = 4'd0;
        #1;
        check("ar_pred0", 32'(pred_state), 32'd1);
        rst = 1'b0;
        tick();
        check("ar_valid_after", 32'(upd_valid), 32'd0);

        // Five qualifying reports, ready low: four queued, fifth dropped
        for (int i = 1; i <= 5; i++) begin
            report(32'(i * 4 + 32'h40), 32'(i * 4 + 32'h140), 1'b1);
            tick();
            if (i < 5) begin
                check($sformatf("ov_drop_%0d", i), 32'(upd_dropped), 32'd0);
                check_head($sformatf("ov_head_%0d", i), 32'h44, 32'h144);
            end
        end
        idle();
        check("ov_drop_pulse", 32'(upd_dropped), 32'd1);
        tick();
        check("ov_drop_clear", 32'(upd_dropped), 32'd0);
        check_head("ov_head_hold", 32'h44, 32'h144);
        upd_ready = 1'b1;
        tick();
        check_head("ov_drain_2", 32'h48, 32'h148);
        tick();
        check_head("ov_drain_3", 32'h4C, 32'h14C);
        tick();
        check_head("ov_drain_4", 32'h50, 32'h150);
        tick();
        check("ov_drain_empty", 32'(upd_valid), 32'd0);
        upd_ready = 1'b0;

        // Full FIFO with simultaneous pop and push: no drop
        for (int i = 6; i <= 9; i++) begin
            report(32'(i * 4 + 32'h40), 32'(i * 4 + 32'h140), 1'b1);
            tick();
        end
        check_head("fp_head", 32'h58, 32'h158);
        report(32'h68, 32'h168, 1'b1);
        upd_ready = 1'b1;
        tick();
        idle();
        check("fp_drop", 32'(upd_dropped), 32'd0);
        check_head("fp_drain_7", 32'h5C, 32'h15C);
        tick();
        check_head("fp_drain_8", 32'h60, 32'h160);
        tick();
        check_head("fp_drain_9", 32'h64, 32'h164);
        tick();
        check_head("fp_drain_10", 32'h68, 32'h168);
        tick();
        check("fp_empty", 32'(upd_valid), 32'd0);
        check("fp_empty_pc", upd_pc, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
